// File: rtl/mem_unaligned_ctrl.sv
// Unaligned byte/half/word load-store engine in front of a word-wide synchronous RAM.
// Every access reads both candidate words; stores then write back one or two merged words.
//
// state | meaning
// IDLE  | ready for a request
// RD0   | first word address on the RAM
// RD1   | second word address on the RAM, first word returning
// CAP   | second word returning; build load result or merged store words
// WR0   | write merged first word
// WR1   | write merged second word (straddling stores only)
// RSP   | one-cycle response pulse
module mem_unaligned_ctrl #(
    parameter  int DATA_W = 32,
    parameter  int ADDR_W = 8,
    localparam int WB     = DATA_W / 8,
    localparam int OFF_W  = $clog2(WB),
    localparam int RAW    = ADDR_W - OFF_W
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              req_valid_i,
    output logic              req_ready_o,
    input  logic              req_write_i,
    input  logic [1:0]        req_size_i,
    input  logic [ADDR_W-1:0] req_addr_i,
    input  logic [DATA_W-1:0] req_wdata_i,
    output logic              rsp_valid_o,
    output logic [DATA_W-1:0] rsp_rdata_o,
    output logic [RAW-1:0]    mem_addr_o,
    output logic              mem_we_o,
    output logic [DATA_W-1:0] mem_din_o,
    input  logic [DATA_W-1:0] mem_dout_i
);

    localparam int N_W = OFF_W + 1;
    localparam int SW  = N_W + 1;

    typedef enum logic [2:0] {
        S_IDLE, S_RD0, S_RD1, S_CAP, S_WR0, S_WR1, S_RSP
    } state_t;

    state_t              state_q, state_d;
    logic                wr_q, wr_d;
    logic [N_W-1:0]      n_q, n_d;
    logic [OFF_W-1:0]    off_q, off_d;
    logic [RAW-1:0]      w0_q, w0_d;
    logic [RAW-1:0]      w1_q, w1_d;
    logic                span_q, span_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic [DATA_W-1:0]   word0_q, word0_d;
    logic [DATA_W-1:0]   word1_q, word1_d;
    logic [DATA_W-1:0]   rsp_rdata_q, rsp_rdata_d;
    logic [RAW-1:0]      mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0]   mem_din_q, mem_din_d;

    logic [N_W-1:0]      n_req;
    logic [OFF_W-1:0]    off_req;
    logic [RAW-1:0]      w0_req;
    logic                span_req;

    logic [31:0]         head_sh;
    logic [31:0]         tail_sh;
    logic [2*DATA_W-1:0] cat;
    logic [DATA_W-1:0]   wdata_left;
    logic [DATA_W-1:0]   mask_left;
    logic [2*DATA_W-1:0] ins;
    logic [2*DATA_W-1:0] mask;
    logic [2*DATA_W-1:0] merged;
    logic [DATA_W-1:0]   load_data;

    always_comb begin
        case (req_size_i)
            2'd0:    n_req = N_W'(1);
            2'd1:    n_req = N_W'(2);
            default: n_req = N_W'(WB);
        endcase
    end

    assign off_req  = req_addr_i[OFF_W-1:0];
    assign w0_req   = req_addr_i[ADDR_W-1:OFF_W];
    assign span_req = (SW'(off_req) + SW'(n_req)) > SW'(WB);

    // Both words viewed as one big-endian byte string; offset 0 is the MSB byte of word0.
    assign head_sh    = 32'(off_q) << 3;
    assign tail_sh    = (32'(WB) - 32'(n_q)) << 3;
    assign cat        = {word0_q, mem_dout_i};
    assign load_data  = DATA_W'((cat << head_sh) >> (32'(DATA_W) + tail_sh));
    assign wdata_left = wdata_q << tail_sh;
    assign mask_left  = {DATA_W{1'b1}} << tail_sh;
    assign ins        = {wdata_left, {DATA_W{1'b0}}} >> head_sh;
    assign mask       = {mask_left, {DATA_W{1'b0}}} >> head_sh;
    assign merged     = (cat & ~mask) | (ins & mask);

    always_comb begin
        state_d     = state_q;
        wr_d        = wr_q;
        n_d         = n_q;
        off_d       = off_q;
        w0_d        = w0_q;
        w1_d        = w1_q;
        span_d      = span_q;
        wdata_d     = wdata_q;
        word0_d     = word0_q;
        word1_d     = word1_q;
        rsp_rdata_d = rsp_rdata_q;
        mem_addr_d  = mem_addr_q;
        mem_din_d   = mem_din_q;
        case (state_q)
            S_IDLE: begin
                if (req_valid_i) begin
                    wr_d       = req_write_i;
                    n_d        = n_req;
                    off_d      = off_req;
                    w0_d       = w0_req;
                    w1_d       = w0_req + RAW'(1);
                    span_d     = span_req;
                    wdata_d    = req_wdata_i;
                    mem_addr_d = w0_req;
                    state_d    = S_RD0;
                end
            end
            S_RD0: begin
                mem_addr_d = w1_q;
                state_d    = S_RD1;
            end
            S_RD1: begin
                word0_d = mem_dout_i;
                state_d = S_CAP;
            end
            S_CAP: begin
                if (wr_q) begin
                    mem_din_d  = merged[2*DATA_W-1 -: DATA_W];
                    word1_d    = merged[DATA_W-1:0];
                    mem_addr_d = w0_q;
                    state_d    = S_WR0;
                end else begin
                    rsp_rdata_d = load_data;
                    state_d     = S_RSP;
                end
            end
            S_WR0: begin
                if (span_q) begin
                    mem_din_d  = word1_q;
                    mem_addr_d = w1_q;
                    state_d    = S_WR1;
                end else begin
                    state_d = S_RSP;
                end
            end
            S_WR1:   state_d = S_RSP;
            S_RSP:   state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= S_IDLE;
            wr_q        <= 1'b0;
            n_q         <= '0;
            off_q       <= '0;
            w0_q        <= '0;
            w1_q        <= '0;
            span_q      <= 1'b0;
            wdata_q     <= '0;
            word0_q     <= '0;
            word1_q     <= '0;
            rsp_rdata_q <= '0;
            mem_addr_q  <= '0;
            mem_din_q   <= '0;
        end else begin
            state_q     <= state_d;
            wr_q        <= wr_d;
            n_q         <= n_d;
            off_q       <= off_d;
            w0_q        <= w0_d;
            w1_q        <= w1_d;
            span_q      <= span_d;
            wdata_q     <= wdata_d;
            word0_q     <= word0_d;
            word1_q     <= word1_d;
            rsp_rdata_q <= rsp_rdata_d;
            mem_addr_q  <= mem_addr_d;
            mem_din_q   <= mem_din_d;
        end
    end

    assign req_ready_o = (state_q == S_IDLE);
    assign rsp_valid_o = (state_q == S_RSP);
    assign rsp_rdata_o = rsp_rdata_q;
    assign mem_addr_o  = mem_addr_q;
    assign mem_din_o   = mem_din_q;
    // Gated by reset so an abort on a write cycle never commits.
    assign mem_we_o    = ((state_q == S_WR0) || (state_q == S_WR1)) && !rst_i;

endmodule

// File: tb/tb_mem_unaligned_ctrl.sv
// Directed bench for mem_unaligned_ctrl with a behavioural synchronous RAM (64 x 32).
module tb_mem_unaligned_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [1:0]  req_size;
    logic [7:0]  req_addr;
    logic [31:0] req_wdata;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic [5:0]  mem_addr;
    logic        mem_we;
    logic [31:0] mem_din;
    logic [31:0] mem_dout;

    logic [31:0] ram [0:63];
    logic        pre_we;
    logic [5:0]  pre_addr;
    logic [31:0] pre_data;

    int tests = 0;
    int fails = 0;

    mem_unaligned_ctrl #(.DATA_W(32), .ADDR_W(8)) dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .req_valid_i (req_valid),
        .req_ready_o (req_ready),
        .req_write_i (req_write),
        .req_size_i  (req_size),
        .req_addr_i  (req_addr),
        .req_wdata_i (req_wdata),
        .rsp_valid_o (rsp_valid),
        .rsp_rdata_o (rsp_rdata),
        .mem_addr_o  (mem_addr),
        .mem_we_o    (mem_we),
        .mem_din_o   (mem_din),
        .mem_dout_i  (mem_dout)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (pre_we)
            ram[pre_addr] <= pre_data;
        else if (mem_we)
            ram[mem_addr] <= mem_din;
        mem_dout <= ram[mem_addr];
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic preload(input logic [5:0] a, input logic [31:0] d);
        pre_addr = a;
        pre_data = d;
        pre_we   = 1'b1;
        step();
        pre_we   = 1'b0;
    endtask

    task automatic wait_idle(input string tag);
        int n;
        n = 0;
        while (!req_ready && n < 20) begin
            step();
            n++;
        end
        chk(tag, 32'(req_ready), 32'd1);
    endtask

    // One request; returns response cycle count (0 on timeout), write pulses,
    // cycles where req_ready was high while busy, and the first two RAM addresses.
    task automatic do_req(input logic wr, input logic [1:0] sz, input logic [7:0] addr,
                          input logic [31:0] wd, output int lat, output int wes,
                          output int busy_rdy, output logic [5:0] a0, output logic [5:0] a1);
        int n;
        wait_idle("idle_before_req");
        req_write = wr;
        req_size  = sz;
        req_addr  = addr;
        req_wdata = wd;
        req_valid = 1'b1;
        step();
        req_valid = 1'b0;
        lat = 0; wes = 0; busy_rdy = 0; a0 = '0; a1 = '0; n = 1;
        while (lat == 0 && n <= 12) begin
            if (n == 1) a0 = mem_addr;
            if (n == 2) a1 = mem_addr;
            if (mem_we) wes++;
            if (req_ready) busy_rdy++;
            if (rsp_valid) lat = n;
            step();
            n++;
        end
    endtask

    int lat, wes, busy_rdy, n, acc, rsps, both;
    logic [5:0] a0, a1;

    initial begin
        rst = 1'b1; req_valid = 1'b0; req_write = 1'b0; req_size = 2'd0;
        req_addr = '0; req_wdata = '0; pre_we = 1'b0; pre_addr = '0; pre_data = '0;
        repeat (3) step();
        chk("rst_ready", 32'(req_ready), 32'd1);
        chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("rst_rdata", rsp_rdata, 32'h0);
        chk("rst_mem_addr", 32'(mem_addr), 32'd0);
        chk("rst_mem_we", 32'(mem_we), 32'd0);
        chk("rst_mem_din", mem_din, 32'h0);
        rst = 1'b0;
        for (int i = 0; i < 64; i++) preload(6'(i), 32'h0);
        preload(6'd0, 32'h11223344);
        preload(6'd1, 32'h55667788);
        preload(6'd63, 32'hA0B0C0D0);

        // 1: load half @0x01
        do_req(1'b0, 2'd1, 8'h01, 32'h0, lat, wes, busy_rdy, a0, a1);
        chk("t1_latency", 32'(lat), 32'd4);
        chk("t1_rdata", rsp_rdata, 32'h00002233);
        chk("t1_ready_low_busy", 32'(busy_rdy), 32'd0);
        chk("t1_ready_back", 32'(req_ready), 32'd1);
        chk("t1_no_write", 32'(wes), 32'd0);
        chk("t1_ram0", ram[0], 32'h11223344);
        chk("t1_ram1", ram[1], 32'h55667788);

        // 2: load word @0x03, load byte @0x07
        do_req(1'b0, 2'd2, 8'h03, 32'h0, lat, wes, busy_rdy, a0, a1);
        chk("t2_word_latency", 32'(lat), 32'd4);
        chk("t2_word_rdata", rsp_rdata, 32'h44556677);
        do_req(1'b0, 2'd0, 8'h07, 32'h0, lat, wes, busy_rdy, a0, a1);
        chk("t2_byte_rdata", rsp_rdata, 32'h00000088);

        // 3: straddling store half
        do_req(1'b1, 2'd1, 8'h03, 32'h0000ABCD, lat, wes, busy_rdy, a0, a1);
        chk("t3_latency", 32'(lat), 32'd6);
        chk("t3_we_pulses", 32'(wes), 32'd2);
        chk("t3_ram0", ram[0], 32'h112233AB);
        chk("t3_ram1", ram[1], 32'hCD667788);
        chk("t3_rdata_held", rsp_rdata, 32'h00000088);
        chk("t3_ready_low_busy", 32'(busy_rdy), 32'd0);

        // 4: wrap from word 63 to word 0
        do_req(1'b0, 2'd1, 8'hFF, 32'h0, lat, wes, busy_rdy, a0, a1);
        chk("t4_load_rdata", rsp_rdata, 32'h0000D011);
        chk("t4_load_addr0", 32'(a0), 32'd63);
        chk("t4_load_addr1", 32'(a1), 32'd0);
        preload(6'd0, 32'h11223344);
        do_req(1'b1, 2'd2, 8'hFE, 32'hDEADBEEF, lat, wes, busy_rdy, a0, a1);
        chk("t4_store_latency", 32'(lat), 32'd6);
        chk("t4_ram63", ram[63], 32'hA0B0DEAD);
        chk("t4_ram0", ram[0], 32'hBEEF3344);

        // 5: reset while in WR1 of the straddling store
        preload(6'd0, 32'h11223344);
        preload(6'd1, 32'h55667788);
        wait_idle("t5_idle");
        req_write = 1'b1; req_size = 2'd1; req_addr = 8'h03; req_wdata = 32'h0000ABCD;
        req_valid = 1'b1;
        step();
        req_valid = 1'b0;
        wes = 0; n = 0; rsps = 0;
        while (wes < 2 && n < 12) begin
            if (rsp_valid) rsps++;
            if (mem_we) wes++;
            if (wes < 2) begin
                step();
                n++;
            end
        end
        chk("t5_reached_wr1", 32'(wes), 32'd2);
        rst = 1'b1;
        #1;
        chk("t5_we_gated", 32'(mem_we), 32'd0);
        step();
        rst = 1'b0;
        chk("t5_ready_after_rst", 32'(req_ready), 32'd1);
        chk("t5_no_rsp_now", 32'(rsp_valid), 32'd0);
        step();
        if (rsp_valid) rsps++;
        chk("t5_no_rsp", 32'(rsps), 32'd0);
        chk("t5_ram0", ram[0], 32'h112233AB);
        chk("t5_ram1", ram[1], 32'h55667788);

        // 6: req_valid held while busy, size 3 load @0x00
        preload(6'd0, 32'h11223344);
        wait_idle("t6_idle");
        req_write = 1'b0; req_size = 2'd3; req_addr = 8'h00; req_wdata = 32'h0;
        req_valid = 1'b1;
        acc = 0; rsps = 0; both = 0;
        for (int i = 0; i < 12; i++) begin
            if (req_valid && req_ready) acc++;
            if (rsp_valid) begin
                rsps++;
                chk("t6_rdata", rsp_rdata, 32'h11223344);
            end
            if (rsp_valid && req_ready) both++;
            step();
        end
        req_valid = 1'b0;
        n = 0;
        while (!req_ready && n < 20) begin
            if (rsp_valid) begin
                rsps++;
                chk("t6_rdata_tail", rsp_rdata, 32'h11223344);
            end
            if (rsp_valid && req_ready) both++;
            step();
            n++;
        end
        chk("t6_accepts", 32'(acc), 32'd3);
        chk("t6_responses", 32'(rsps), 32'd3);
        chk("t6_rsp_ready_overlap", 32'(both), 32'd0);

        // 6: non-straddling store byte
        do_req(1'b1, 2'd0, 8'h02, 32'h0000005A, lat, wes, busy_rdy, a0, a1);
        chk("t6_store_latency", 32'(lat), 32'd5);
        chk("t6_store_we", 32'(wes), 32'd1);
        chk("t6_ram0", ram[0], 32'h11225A44);
        chk("t6_ram1_untouched", ram[1], 32'h55667788);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
